regfile_mp: RTL and testbench

Parametrised multi-port general-purpose register file for the MIPS core. It generalises the 2-read/1-write file to NUM_RD read ports and NUM_WR write ports, with same-cycle write-to-read bypass and a configurable hardwired zero register. It adds a sequential clear engine that zeroes every entry after reset or on request, and reports `busy` while clearing. It sits between ID (reads) and WB (writes); a future dual-issue pipeline uses the extra ports.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_rd_port.sv | 50 +++++
 rtl/regfile_mp.sv | 101 ++++++++++
 tb/tb_regfile_mp.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the multi-port register file.
// Default widths match the ID and WB stages of the MIPS core.
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 5;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [DEFAULT_DATA_W-1:0] ZERO_WORD = '0;

    typedef logic [0:0] state_t;
    localparam state_t CLEAR = 1'b0;
    localparam state_t RUN   = 1'b1;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: blanking while cleared, zero register,
// then same-cycle bypass from the write ports (highest port index wins).
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     rst,
    input  logic                     busy,
    input  logic                     ren,
    input  logic [ADDR_W-1:0]        raddr,
    input  logic [DATA_W-1:0]        rf_word,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_WR-1:0]        we,
    output logic [DATA_W-1:0]        rdata_c
);

    logic              hit;
    logic [DATA_W-1:0] bypass;

    // Ascending scan so the highest matching write port overrides lower ones.
    always_comb begin
        hit    = DISABLE;
        bypass = '0;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (we[j] && (waddr[j*ADDR_W +: ADDR_W] == raddr)) begin
                hit    = ENABLE;
                bypass = wdata[j*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rdata_c = rf_word;
        if (rst || busy) begin
            rdata_c = '0;
        end else if (!ren) begin
            rdata_c = '0;
        end else if ((ZERO_REG != 0) && (raddr == '0)) begin
            rdata_c = '0;
        end else if (hit) begin
            rdata_c = bypass;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port general-purpose register file with write-to-read bypass,
// optional hardwired zero register and a one-entry-per-cycle clear engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    input  logic [NUM_RD-1:0]        ren,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_WR-1:0]        we,
    input  logic                     init_req,
    output logic                     busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   rf_q [DEPTH];
    logic [DATA_W-1:0]   rf_d [DEPTH];

    // Clear sweep runs DEPTH cycles, then hands over to RUN.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (rst) begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
        end else if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = RUN;
            end
        end else if (init_req) begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
        end
        busy_d = (state_d == CLEAR);
    end

    // Array update: clear one entry per cycle, or commit writes in RUN.
    always_comb begin
        rf_d = rf_q;
        if (!rst) begin
            if (state_q == CLEAR) begin
                rf_d[clr_cnt_q] = DATA_W'(ZERO_WORD);
            end else begin
                for (int unsigned j = 0; j < NUM_WR; j++) begin
                    if (we[j] && !((ZERO_REG != 0) && (waddr[j*ADDR_W +: ADDR_W] == '0))) begin
                        rf_d[waddr[j*ADDR_W +: ADDR_W]] = wdata[j*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        clr_cnt_q <= clr_cnt_d;
        busy_q    <= busy_d;
    end

    always_ff @(posedge clk) begin
        rf_q <= rf_d;
    end

    assign busy = busy_q;

    for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = raddr[i*ADDR_W +: ADDR_W];

        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .rst     (rst),
            .busy    (busy_q),
            .ren     (ren[i]),
            .raddr   (ra),
            .rf_word (rf_q[ra]),
            .waddr   (waddr),
            .wdata   (wdata),
            .we      (we),
            .rdata_c (rdata[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (zero register on/off) share stimulus
// and are compared every cycle against an array-based behavioural model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  raddr;
    logic [1:0]  ren;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  we;
    logic        init_req;
    logic [63:0] rdata_a, rdata_b;
    logic        busy_a, busy_b;

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .raddr(raddr), .ren(ren), .rdata(rdata_a),
        .waddr(waddr), .wdata(wdata), .we(we), .init_req(init_req), .busy(busy_a)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .raddr(raddr), .ren(ren), .rdata(rdata_b),
        .waddr(waddr), .wdata(wdata), .we(we), .init_req(init_req), .busy(busy_b)
    );

    // Model: contents per instance (0: zero register, 1: plain) and cycles of clear left.
    logic [31:0] mrf [2][32];
    int          clr_left = 32;

    always @(posedge clk) begin
        if (rst) begin
            clr_left = 32;
        end else if (clr_left > 0) begin
            mrf[0][32-clr_left] = 32'h0;
            mrf[1][32-clr_left] = 32'h0;
            clr_left = clr_left - 1;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (we[j]) begin
                    if (waddr[j*5 +: 5] != 5'd0) mrf[0][waddr[j*5 +: 5]] = wdata[j*32 +: 32];
                    mrf[1][waddr[j*5 +: 5]] = wdata[j*32 +: 32];
                end
            end
            if (init_req) clr_left = 32;
        end
    end

    function automatic logic [31:0] exp_rd(input int m, input int i);
        logic [4:0]  a;
        logic [31:0] v;
        a = raddr[i*5 +: 5];
        if (rst || clr_left > 0) return 32'h0;
        if (!ren[i]) return 32'h0;
        if (m == 0 && a == 5'd0) return 32'h0;
        v = mrf[m][a];
        for (int j = 0; j < 2; j++)
            if (we[j] && waddr[j*5 +: 5] == a) v = wdata[j*32 +: 32];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_zr", 32'(busy_a), 32'(clr_left > 0));
            check("busy_nz", 32'(busy_b), 32'(clr_left > 0));
            check("rd0_zr", rdata_a[31:0],  exp_rd(0, 0));
            check("rd1_zr", rdata_a[63:32], exp_rd(0, 1));
            check("rd0_nz", rdata_b[31:0],  exp_rd(1, 0));
            check("rd1_nz", rdata_b[63:32], exp_rd(1, 1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ren = '0; we = '0; init_req = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy_a === 1'b1 && n < 100) begin
            n++;
            step();
        end
    endtask

    int nb;

    initial begin
        rst = 1'b1; raddr = '0; ren = '0; waddr = '0; wdata = '0; we = '0; init_req = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        check("busy_in_reset", 32'(busy_a), 32'h1);
        rst = 1'b0;
        ren = 2'b11; raddr = {5'd31, 5'd1};
        #2 check("rd_during_clear", rdata_a[31:0], 32'h0);
        count_busy(nb);
        check("busy_cycles_after_reset", 32'(nb), 32'd32);

        for (int a = 1; a < 32; a++) begin
            raddr = {5'(a), 5'(a)};
            #2 check("cleared_entry", rdata_b[31:0], 32'h0);
            step();
        end

        // Basic write/read through port 0.
        idle();
        we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'h12345678};
        step();
        idle(); ren = 2'b01; raddr = {5'd0, 5'd5};
        #2 check("rd_r5", rdata_a[31:0], 32'h12345678);
        ren = 2'b00;
        #1 check("rd_r5_ren0", rdata_a[31:0], 32'h0);
        step();

        // Same-address conflict on both write ports with a bypassed read.
        we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h5555FFFF, 32'hAAAA0000};
        ren = 2'b10; raddr = {5'd7, 5'd0};
        #2 check("bypass_conflict", rdata_a[63:32], 32'h5555FFFF);
        step();
        we = 2'b00;
        #2 check("conflict_commit", rdata_a[63:32], 32'h5555FFFF);
        step();

        // Zero register on instance a, ordinary entry on instance b.
        we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'hFFFFFFFF};
        ren = 2'b01; raddr = {5'd0, 5'd0};
        #2 check("r0_zr_same", rdata_a[31:0], 32'h0);
        check("r0_nz_same", rdata_b[31:0], 32'hFFFFFFFF);
        step();
        we = 2'b00;
        #2 check("r0_zr_next", rdata_a[31:0], 32'h0);
        check("r0_nz_next", rdata_b[31:0], 32'hFFFFFFFF);
        step();

        // Clear on request; a write issued while clearing must vanish.
        we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'hDEADBEEF};
        step();
        idle(); init_req = 1'b1;
        step();
        init_req = 1'b0;
        check("busy_after_init", 32'(busy_a), 32'h1);
        we = 2'b10; waddr = {5'd3, 5'd0}; wdata = {32'h01234567, 32'h0};
        step();
        we = 2'b00;
        count_busy(nb);
        check("busy_cycles_init", 32'(nb + 1), 32'd32);
        ren = 2'b11; raddr = {5'd3, 5'd3};
        #2 check("r3_cleared", rdata_b[63:32], 32'h0);
        step();

        // Reset in the middle of a clear restarts the full sweep.
        idle(); init_req = 1'b1;
        step();
        init_req = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy(nb);
        check("busy_cycles_midclear", 32'(nb), 32'd32);

        // Randomized traffic with occasional clear requests and resets.
        for (int c = 0; c < 3000; c++) begin
            ren   = 2'($urandom_range(0, 3));
            raddr = {(($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7))),
                     (($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)))};
            we    = 2'($urandom_range(0, 3));
            waddr = {(($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7))),
                     (($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)))};
            wdata = {32'($urandom), 32'($urandom)};
            init_req = ($urandom_range(0, 199) == 0);
            rst      = ($urandom_range(0, 599) == 0);
            step();
        end
        idle(); rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
